// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM state
// constants and the default datapath width.
package alu_arbiter_pkg;

    localparam int NBITS_DEFAULT = 8;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_SRL     = 3'd2;
    localparam logic [2:0] OP_SLL     = 3'd3;
    localparam logic [2:0] OP_LT      = 3'd4;
    localparam logic [2:0] OP_EQ      = 3'd5;
    localparam logic [2:0] OP_GT      = 3'd6;
    localparam logic [2:0] OP_INVALID = 3'd7;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

endpackage

// File: rtl/alu_arbiter_2req_alu8_datapath.sv
// Purely combinational unsigned ALU shared by both requesters.
module alu8_datapath
    import alu_arbiter_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic [2:0]       op,
    output logic [NBITS-1:0] out
);

    // Shifts use the full operand as the amount, so large amounts naturally yield 0.
    always_comb begin
        out = '0;
        case (op)
            OP_ADD:  out = in0 + in1;
            OP_SUB:  out = in0 - in1;
            OP_SRL:  out = in0 >> in1;
            OP_SLL:  out = in0 << in1;
            OP_LT:   out = {{(NBITS-1){1'b0}}, (in0 < in1)};
            OP_EQ:   out = {{(NBITS-1){1'b0}}, (in0 == in1)};
            OP_GT:   out = {{(NBITS-1){1'b0}}, (in0 > in1)};
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_2req.sv
// Round-robin arbiter sharing one ALU between two val/rdy requesters with a
// single registered result slot. Optional counters via ALU_ARBITER_2REQ_STATS_EN.
module alu_arbiter_2req
    import alu_arbiter_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
`ifdef ALU_ARBITER_2REQ_STATS_EN
    ,
    parameter int CNT_BITS = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [NBITS-1:0] req0_in0,
    input  logic [NBITS-1:0] req0_in1,
    input  logic [2:0]       req0_op,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [NBITS-1:0] req1_in0,
    input  logic [NBITS-1:0] req1_in1,
    input  logic [2:0]       req1_op,
    output logic             resp0_val,
    input  logic             resp0_rdy,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output logic [NBITS-1:0] resp_data
`ifdef ALU_ARBITER_2REQ_STATS_EN
    ,
    output logic [CNT_BITS-1:0] stat_cnt0,
    output logic [CNT_BITS-1:0] stat_cnt1
`endif
);

    logic             state;
    logic             own;
    logic             prio;
    logic [NBITS-1:0] result_q;

    logic             grant_any;
    logic             grant;
    logic             resp_fire;
    logic             slot_free;
    logic             req_fire;
    logic [NBITS-1:0] alu_in0;
    logic [NBITS-1:0] alu_in1;
    logic [2:0]       alu_op;
    logic [NBITS-1:0] alu_out;

    // The priority pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_any = req0_val | req1_val;
        grant     = 1'b0;
        if (req0_val && req1_val) begin
            grant = prio;
        end else if (req1_val) begin
            grant = 1'b1;
        end
    end

    assign resp0_val = (state == ST_HOLD) && !own;
    assign resp1_val = (state == ST_HOLD) && own;
    assign resp_fire = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

    // Draining the slot this cycle frees it for a new issue in the same cycle.
    assign slot_free = !reset && ((state == ST_IDLE) || resp_fire);
    assign req0_rdy  = slot_free && grant_any && !grant;
    assign req1_rdy  = slot_free && grant_any && grant;
    assign req_fire  = (req0_val && req0_rdy) || (req1_val && req1_rdy);

    assign alu_in0 = grant ? req1_in0 : req0_in0;
    assign alu_in1 = grant ? req1_in1 : req0_in1;
    assign alu_op  = grant ? req1_op  : req0_op;

    alu8_datapath #(
        .NBITS(NBITS)
    ) u_alu (
        .in0(alu_in0),
        .in1(alu_in1),
        .op (alu_op),
        .out(alu_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            own      <= 1'b0;
            prio     <= 1'b0;
            result_q <= '0;
        end else if (req_fire) begin
            state    <= ST_HOLD;
            own      <= grant;
            prio     <= ~grant;
            result_q <= alu_out;
        end else if (resp_fire) begin
            state    <= ST_IDLE;
        end
    end

    assign resp_data = result_q;

`ifdef ALU_ARBITER_2REQ_STATS_EN
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (resp0_val && resp0_rdy && (stat_cnt0 != '1)) begin
                stat_cnt0 <= stat_cnt0 + CNT_ONE;
            end
            if (resp1_val && resp1_rdy && (stat_cnt1 != '1)) begin
                stat_cnt1 <= stat_cnt1 + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Self-checking bench for alu_arbiter_2req: directed scenarios plus a random
// run against a transaction-level reference model.
module tb_alu_arbiter_2req;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_val, req0_rdy, req1_val, req1_rdy;
    logic [7:0] req0_in0, req0_in1, req1_in0, req1_in1;
    logic [2:0] req0_op, req1_op;
    logic       resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [7:0] resp_data;
`ifdef ALU_ARBITER_2REQ_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_arbiter_2req dut (
`ifdef ALU_ARBITER_2REQ_STATS_EN
        .stat_cnt0(stat_cnt0),
        .stat_cnt1(stat_cnt1),
`endif
        .clk      (clk),
        .reset    (reset),
        .req0_val (req0_val),
        .req0_rdy (req0_rdy),
        .req0_in0 (req0_in0),
        .req0_in1 (req0_in1),
        .req0_op  (req0_op),
        .req1_val (req1_val),
        .req1_rdy (req1_rdy),
        .req1_in0 (req1_in0),
        .req1_in1 (req1_in1),
        .req1_op  (req1_op),
        .resp0_val(resp0_val),
        .resp0_rdy(resp0_rdy),
        .resp1_val(resp1_val),
        .resp1_rdy(resp1_rdy),
        .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] get_flags();
        return {req0_rdy, req1_rdy, resp0_val, resp1_val};
    endfunction

    function automatic int alu_ref(int a, int b, int op);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return (b >= 8) ? 0 : a / (1 << b);
            3:       return (b >= 8) ? 0 : (a * (1 << b)) % 256;
            4:       return (a < b) ? 1 : 0;
            5:       return (a == b) ? 1 : 0;
            6:       return (a > b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    // Drives one cycle of inputs at the falling edge and lets them settle.
    task automatic apply_stimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                  input logic [2:0] o0, input logic v1, input logic [7:0] a1,
                                  input logic [7:0] b1, input logic [2:0] o1,
                                  input logic r0, input logic r1);
        @(negedge clk);
        req0_val  = v0;
        req0_in0  = v0 ? a0 : 'x;
        req0_in1  = v0 ? b0 : 'x;
        req0_op   = v0 ? o0 : 'x;
        req1_val  = v1;
        req1_in0  = v1 ? a1 : 'x;
        req1_in1  = v1 ? b1 : 'x;
        req1_op   = v1 ? o1 : 'x;
        resp0_rdy = r0;
        resp1_rdy = r1;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req0_val  = 1'b0;
        req1_val  = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset    = 1'b1;
        req0_val = 1'b1;
        req1_val = 1'b1;
        req0_in0 = 8'd1; req0_in1 = 8'd1; req0_op = 3'd0;
        req1_in0 = 8'd1; req1_in1 = 8'd1; req1_op = 3'd0;
        #1;
        n_checks++;
        if ({req0_rdy, req1_rdy} !== 2'b00)
            $display("[TB] FAIL reset_rdy_low: got %b expected 00", {req0_rdy, req1_rdy});
        else n_pass++;
        @(negedge clk);
        reset    = 1'b0;
        req0_val = 1'b0;
        req1_val = 1'b0;
        #1;
        n_checks++;
        if (get_flags() !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", get_flags());
        else n_pass++;
        n_checks++;
        if (resp_data !== 8'd0)
            $display("[TB] FAIL reset_data: got %0d expected 0", resp_data);
        else n_pass++;
    endtask

    task automatic test_single();
        apply_stimulus(1, 42, 9, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1000)
            $display("[TB] FAIL single_issue: got %b expected 1000", get_flags());
        else n_pass++;
        apply_stimulus(1, 42, 13, 1, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1010)
            $display("[TB] FAIL single_b2b_flags: got %b expected 1010", get_flags());
        else n_pass++;
        n_checks++;
        if (resp_data !== 8'd51)
            $display("[TB] FAIL single_add: got %0d expected 51", resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0010 || resp_data !== 8'd29)
            $display("[TB] FAIL single_sub: got flags %b data %0d expected 0010 data 29",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0000)
            $display("[TB] FAIL single_idle: got %b expected 0000", get_flags());
        else n_pass++;
    endtask

    task automatic test_alternate();
        apply_reset();
        apply_stimulus(1, 13, 2, 2, 1, 13, 2, 3, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1000)
            $display("[TB] FAIL alt_grant0: got %b expected 1000", get_flags());
        else n_pass++;
        apply_stimulus(1, 1, 2, 4, 1, 13, 2, 3, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0110 || resp_data !== 8'd3)
            $display("[TB] FAIL alt_grant1: got flags %b data %0d expected 0110 data 3",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(1, 1, 2, 4, 1, 42, 13, 5, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1001 || resp_data !== 8'd52)
            $display("[TB] FAIL alt_grant2: got flags %b data %0d expected 1001 data 52",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(1, 0, 0, 0, 1, 42, 13, 5, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0110 || resp_data !== 8'd1)
            $display("[TB] FAIL alt_grant3: got flags %b data %0d expected 0110 data 1",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1001 || resp_data !== 8'd0)
            $display("[TB] FAIL alt_eq: got flags %b data %0d expected 1001 data 0",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_backpressure();
        apply_stimulus(0, 0, 0, 0, 1, 2, 1, 6, 1, 0);
        n_checks++;
        if (get_flags() !== 4'b0100)
            $display("[TB] FAIL bp_issue: got %b expected 0100", get_flags());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 5, 3, 0, 0, 0, 0, 0, 1, 0);
            n_checks++;
            if (get_flags() !== 4'b0001 || resp_data !== 8'd1)
                $display("[TB] FAIL bp_stall%0d: got flags %b data %0d expected 0001 data 1",
                         i, get_flags(), resp_data);
            else n_pass++;
        end
        apply_stimulus(1, 5, 3, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b1001)
            $display("[TB] FAIL bp_release: got %b expected 1001", get_flags());
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0010 || resp_data !== 8'd8)
            $display("[TB] FAIL bp_followup: got flags %b data %0d expected 0010 data 8",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    task automatic test_edge_cases();
        logic [7:0] ea[5] = '{8'd42, 8'd42, 8'd1, 8'd1, 8'd200};
        logic [7:0] eb[5] = '{8'd13, 8'd9, 8'd8, 8'd2, 8'd100};
        logic [2:0] eo[5] = '{3'd7, 3'd2, 3'd3, 3'd1, 3'd0};
        logic [7:0] ee[5] = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd44};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, ea[i], eb[i], eo[i], 0, 0, 0, 0, 1, 1);
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            n_checks++;
            if (get_flags() !== 4'b0010 || resp_data !== ee[i])
                $display("[TB] FAIL edge_case%0d: got flags %b data %0d expected 0010 data %0d",
                         i, get_flags(), resp_data, ee[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        apply_stimulus(1, 7, 7, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        reset     = 1'b1;
        req0_val  = 1'b1; req0_in0 = 8'd3; req0_in1 = 8'd4; req0_op = 3'd0;
        req1_val  = 1'b1; req1_in0 = 8'd9; req1_in1 = 8'd9; req1_op = 3'd0;
        resp0_rdy = 1'b0;
        #1;
        n_checks++;
        if ({req0_rdy, req1_rdy} !== 2'b00)
            $display("[TB] FAIL midreset_rdy: got %b expected 00", {req0_rdy, req1_rdy});
        else n_pass++;
        @(negedge clk);
        reset     = 1'b0;
        resp0_rdy = 1'b1;
        #1;
        n_checks++;
        if (get_flags() !== 4'b1000 || resp_data !== 8'd0)
            $display("[TB] FAIL midreset_state: got flags %b data %0d expected 1000 data 0",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (get_flags() !== 4'b0010 || resp_data !== 8'd7)
            $display("[TB] FAIL midreset_req0_first: got flags %b data %0d expected 0010 data 7",
                     get_flags(), resp_data);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

`ifdef ALU_ARBITER_2REQ_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 5) apply_stimulus(1, 8'(i), 1, 0, 0, 0, 0, 0, 1, 1);
            else       apply_stimulus(0, 0, 0, 0, 1, 8'(i), 1, 0, 1, 1);
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (stat_cnt0 !== 16'd5 || stat_cnt1 !== 16'd3)
            $display("[TB] FAIL stats_counts: got %0d/%0d expected 5/3", stat_cnt0, stat_cnt1);
        else n_pass++;
        apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (stat_cnt0 !== 16'd5 || stat_cnt1 !== 16'd3)
            $display("[TB] FAIL stats_stall: got %0d/%0d expected 5/3", stat_cnt0, stat_cnt1);
        else n_pass++;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (stat_cnt0 !== 16'd6)
            $display("[TB] FAIL stats_after_stall: got %0d expected 6", stat_cnt0);
        else n_pass++;
        apply_reset();
        #1;
        n_checks++;
        if (stat_cnt0 !== 16'd0 || stat_cnt1 !== 16'd0)
            $display("[TB] FAIL stats_reset: got %0d/%0d expected 0/0", stat_cnt0, stat_cnt1);
        else n_pass++;
    endtask
`endif

    // Reference: one slot holding (owner, value); a tie goes to the requester
    // that did not win the previous issue.
    task automatic test_random();
        int slot_owner = -1;
        int last_winner = 1;
        int slot_data = 0;
        int drains[2] = '{0, 0};
        int bad = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic v0, v1, r0, r1;
            int a0, b0, o0, a1, b1, o1, winner;
            bit drained, can_issue;
            logic [3:0] exp_flags;
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            a0 = $urandom_range(0, 255);
            a1 = $urandom_range(0, 255);
            b0 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            b1 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            o0 = $urandom_range(0, 7);
            o1 = $urandom_range(0, 7);
            apply_stimulus(v0, 8'(a0), 8'(b0), 3'(o0), v1, 8'(a1), 8'(b1), 3'(o1), r0, r1);

            drained   = (slot_owner == 0 && r0) || (slot_owner == 1 && r1);
            can_issue = (slot_owner < 0) || drained;
            winner    = -1;
            if (v0 && v1) winner = 1 - last_winner;
            else if (v0)  winner = 0;
            else if (v1)  winner = 1;
            exp_flags = {can_issue && winner == 0, can_issue && winner == 1,
                         slot_owner == 0, slot_owner == 1};

            n_checks++;
            if (get_flags() !== exp_flags) begin
                if (bad < 10)
                    $display("[TB] FAIL rand_flags cycle %0d: got %b expected %b",
                             cyc, get_flags(), exp_flags);
                bad++;
            end else n_pass++;
            if (slot_owner >= 0) begin
                n_checks++;
                if (resp_data !== 8'(slot_data)) begin
                    if (bad < 10)
                        $display("[TB] FAIL rand_data cycle %0d: got %0d expected %0d",
                                 cyc, resp_data, slot_data);
                    bad++;
                end else n_pass++;
            end

            if (drained) drains[slot_owner]++;
            if (can_issue && winner >= 0) begin
                slot_data   = (winner == 0) ? alu_ref(a0, b0, o0) : alu_ref(a1, b1, o1);
                slot_owner  = winner;
                last_winner = winner;
            end else if (drained) begin
                slot_owner = -1;
            end
        end
`ifdef ALU_ARBITER_2REQ_STATS_EN
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (stat_cnt0 !== 16'(drains[0]) || stat_cnt1 !== 16'(drains[1]))
            $display("[TB] FAIL rand_stats: got %0d/%0d expected %0d/%0d",
                     stat_cnt0, stat_cnt1, drains[0], drains[1]);
        else n_pass++;
`endif
    endtask

    initial begin
        reset     = 1'b1;
        req0_val  = 1'b0;
        req1_val  = 1'b0;
        req0_in0  = '0; req0_in1 = '0; req0_op = '0;
        req1_in0  = '0; req1_in1 = '0; req1_op = '0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_edge_cases();
        test_reset_mid();
`ifdef ALU_ARBITER_2REQ_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
